// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game controller: state codes,
// the hard-coded colour sequence and the one-hot LED encoder.
package simon_pkg;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_PLAY  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [3:0] LED_ALL   = 4'b1111;
    localparam logic [3:0] INIT_LAST = 4'd3;

    // Fixed colour sequence: element i is colour (i mod 4).
    function automatic logic [1:0] SEQ(input int unsigned idx);
        return 2'(idx % 4);
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/simon_btn_edge.sv
// Button press front end: registers the debounced button, turns each press
// into a single-tick event and holds the colour chosen for the check.
module simon_btn_edge (
    input  logic       clk_tick,
    input  logic       reset,
    input  logic       btn_valid_i,
    input  logic [1:0] btn_val_i,
    input  logic       cap_en_i,
    output logic       press_evt_o,
    output logic [1:0] val_o,
    output logic [1:0] btn_cap_o
);

    logic       valid_q;
    logic       valid_qq;
    logic [1:0] val_q;
    logic [1:0] btn_cap;

    always_ff @(posedge clk_tick) begin
        if (reset) begin
            valid_q  <= 1'b0;
            valid_qq <= 1'b0;
            val_q    <= 2'd0;
            btn_cap  <= 2'd0;
        end else begin
            valid_q  <= btn_valid_i;
            valid_qq <= valid_q;
            val_q    <= btn_val_i;
            if (cap_en_i) begin
                btn_cap <= val_q;
            end
        end
    end

    // Rising edge of the registered valid: one event per press, however long it is held.
    assign press_evt_o = valid_q & ~valid_qq;
    assign val_o       = val_q;
    assign btn_cap_o   = btn_cap;

endmodule

// File: rtl/simon_fsm_hard.sv
// Simon game controller: attract/init, playback of a growing sequence prefix,
// input collection and checking, error and win handling. All outputs registered.
module simon_fsm_hard
    import simon_pkg::*;
#(
    parameter int N          = 4,
    parameter int SHOW_TICKS = 2
) (
    input  logic       clk_tick,
    input  logic       reset,
    input  logic       btn_valid,
    input  logic [1:0] btn_val,
    output logic [3:0] led,
    output logic       error_led,
    output logic [2:0] state,
    output logic [3:0] init_cnt
);

    localparam int RW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = (SHOW_TICKS > 0) ? $clog2(SHOW_TICKS + 1) : 1;

    state_t        state_q, state_d;
    logic [3:0]    init_cnt_q, init_cnt_d;
    logic [RW-1:0] round_cnt, round_cnt_d;
    logic [IW-1:0] input_idx, input_idx_d;
    logic [IW-1:0] play_idx, play_idx_d;
    logic [SW-1:0] show_cnt, show_cnt_d;
    logic [3:0]    led_q, led_d;
    logic          err_q, err_d;

    logic          cap_en;
    logic          press_evt;
    logic [1:0]    val_q;
    logic [1:0]    btn_cap;
    logic          last_play;
    logic          last_input;

    simon_btn_edge u_btn_edge (
        .clk_tick    (clk_tick),
        .reset       (reset),
        .btn_valid_i (btn_valid),
        .btn_val_i   (btn_val),
        .cap_en_i    (cap_en),
        .press_evt_o (press_evt),
        .val_o       (val_q),
        .btn_cap_o   (btn_cap)
    );

    assign last_play  = (RW'(play_idx) + RW'(1)) == round_cnt;
    assign last_input = (RW'(input_idx) + RW'(1)) == round_cnt;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        round_cnt_d = round_cnt;
        input_idx_d = input_idx;
        play_idx_d  = play_idx;
        show_cnt_d  = show_cnt;
        cap_en      = 1'b0;

        case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = S_PLAY;
                    init_cnt_d = '0;
                    play_idx_d = '0;
                    show_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end
            // show_cnt == SHOW_TICKS is the dark gap after each element.
            S_PLAY: begin
                if (show_cnt == SW'(SHOW_TICKS)) begin
                    if (last_play) begin
                        state_d     = S_WAIT;
                        input_idx_d = '0;
                    end else begin
                        play_idx_d = play_idx + 1'b1;
                        show_cnt_d = '0;
                    end
                end else begin
                    show_cnt_d = show_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (press_evt) begin
                    state_d = S_CHECK;
                    cap_en  = 1'b1;
                end
            end
            S_CHECK: begin
                if (btn_cap != SEQ(32'(input_idx))) begin
                    state_d = S_ERROR;
                end else if (!last_input) begin
                    input_idx_d = input_idx + 1'b1;
                    state_d     = S_WAIT;
                end else if (round_cnt != RW'(N)) begin
                    round_cnt_d = round_cnt + 1'b1;
                    input_idx_d = '0;
                    play_idx_d  = '0;
                    show_cnt_d  = '0;
                    state_d     = S_PLAY;
                end else begin
                    round_cnt_d = RW'(1);
                    input_idx_d = '0;
                    init_cnt_d  = '0;
                    state_d     = S_INIT;
                end
            end
            S_ERROR: begin
                if (press_evt) begin
                    round_cnt_d = RW'(1);
                    input_idx_d = '0;
                    play_idx_d  = '0;
                    show_cnt_d  = '0;
                    state_d     = S_PLAY;
                end
            end
            default: begin
                state_d    = S_INIT;
                init_cnt_d = '0;
            end
        endcase

        // LEDs are registered from the state being entered so they line up with it.
        led_d = '0;
        case (state_d)
            S_INIT:  led_d = LED_ALL;
            S_PLAY: begin
                if (show_cnt_d < SW'(SHOW_TICKS)) begin
                    led_d = onehot4(SEQ(32'(play_idx_d)));
                end
            end
            S_CHECK: led_d = onehot4(val_q);
            default: ;
        endcase
        err_d = (state_d == S_ERROR);
    end

    always_ff @(posedge clk_tick) begin
        if (reset) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            round_cnt  <= RW'(1);
            input_idx  <= '0;
            play_idx   <= '0;
            show_cnt   <= '0;
            led_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            round_cnt  <= round_cnt_d;
            input_idx  <= input_idx_d;
            play_idx   <= play_idx_d;
            show_cnt   <= show_cnt_d;
            led_q      <= led_d;
            err_q      <= err_d;
        end
    end

    assign led       = led_q;
    assign error_led = err_q;
    assign state     = state_q;
    assign init_cnt  = init_cnt_q;

endmodule

// File: tb/tb_simon_fsm_hard.sv
// Directed plus randomized bench for simon_fsm_hard, checked against a
// round/index game model and sequence-derived playback patterns.
module tb_simon_fsm_hard;

    localparam int N  = 4;
    localparam int ST = 2;

    localparam int E_INIT  = 0;
    localparam int E_PLAY  = 1;
    localparam int E_WAIT  = 2;
    localparam int E_CHECK = 3;
    localparam int E_ERROR = 4;

    logic       clk_tick;
    logic       reset;
    logic       btn_valid;
    logic [1:0] btn_val;
    logic [3:0] led;
    logic       error_led;
    logic [2:0] state;
    logic [3:0] init_cnt;

    int checks = 0;
    int errors = 0;
    int m_round;
    int m_idx;

    simon_fsm_hard #(.N(N), .SHOW_TICKS(ST)) dut (
        .clk_tick  (clk_tick),
        .reset     (reset),
        .btn_valid (btn_valid),
        .btn_val   (btn_val),
        .led       (led),
        .error_led (error_led),
        .state     (state),
        .init_cnt  (init_cnt)
    );

    initial clk_tick = 1'b0;
    always #5 clk_tick = ~clk_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_tick);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), E_INIT);
        chk({tag, "_init_cnt"}, 32'(init_cnt), 0);
        chk({tag, "_led"}, 32'(led), 0);
        chk({tag, "_error_led"}, 32'(error_led), 0);
        chk({tag, "_round"}, 32'(dut.round_cnt), 1);
        chk({tag, "_idx"}, 32'(dut.input_idx), 0);
    endtask

    // Attract phase: counts 0..3 with all LEDs lit, then playback of round 1.
    task automatic check_init(input logic [3:0] led0);
        chk("init_state0", 32'(state), E_INIT);
        chk("init_cnt0", 32'(init_cnt), 0);
        chk("init_led0", 32'(led), 32'(led0));
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("init_state", 32'(state), E_INIT);
            chk("init_cnt", 32'(init_cnt), c);
            chk("init_led", 32'(led), 32'hF);
        end
        tick();
        chk("init_to_play", 32'(state), E_PLAY);
        chk("init_cnt_clr", 32'(init_cnt), 0);
        chk("init_round", 32'(dut.round_cnt), 1);
        m_round = 1;
        m_idx   = 0;
    endtask

    // Called on the tick PLAY is entered; optionally injects a press that must be ignored.
    task automatic check_playback(input bit poke);
        logic [3:0] exp_q[$];
        logic [3:0] v;
        for (int k = 0; k < m_round; k++) begin
            v = 4'(1 << (k % 4));
            for (int s = 0; s < ST; s++) exp_q.push_back(v);
            exp_q.push_back(4'h0);
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            chk("play_state", 32'(state), E_PLAY);
            chk("play_led", 32'(led), 32'(exp_q[j]));
            if (poke && j == 0) begin
                btn_valid = 1'b1;
                btn_val   = 2'($urandom_range(3));
            end else begin
                btn_valid = 1'b0;
            end
            tick();
        end
        chk("wait_state", 32'(state), E_WAIT);
        chk("wait_led", 32'(led), 0);
        chk("wait_idx", 32'(dut.input_idx), 0);
        m_idx = 0;
    endtask

    // Press from S_WAIT; returns the state the game rules predict at E+2.
    task automatic press_check(input logic [1:0] val, input int hold, output int res);
        btn_valid = 1'b1;
        btn_val   = val;
        tick();
        if (hold == 1) btn_valid = 1'b0;
        chk("lat_still_wait", 32'(state), E_WAIT);
        tick();
        if (hold == 2) btn_valid = 1'b0;
        chk("check_state", 32'(state), E_CHECK);
        chk("check_led", 32'(led), 32'(1) << val);
        if (int'(val) != m_idx % 4) begin
            res = E_ERROR;
        end else if (m_idx < m_round - 1) begin
            m_idx++;
            res = E_WAIT;
        end else if (m_round < N) begin
            m_round++;
            m_idx = 0;
            res = E_PLAY;
        end else begin
            m_round = 1;
            m_idx   = 0;
            res = E_INIT;
        end
        tick();
        chk("result_state", 32'(state), 32'(res));
        chk("result_round", 32'(dut.round_cnt), 32'(m_round));
        chk("result_idx", 32'(dut.input_idx), 32'(m_idx));
        chk("result_err", 32'(error_led), (res == E_ERROR) ? 1 : 0);
        if (hold > 2) begin
            for (int h = 3; h < hold; h++) begin
                tick();
                chk("hold_state", 32'(state), 32'(res));
                chk("hold_idx", 32'(dut.input_idx), 32'(m_idx));
            end
            btn_valid = 1'b0;
            tick();
            chk("hold_release_state", 32'(state), 32'(res));
            chk("hold_release_idx", 32'(dut.input_idx), 32'(m_idx));
        end
    endtask

    task automatic recover();
        btn_valid = 1'b1;
        btn_val   = 2'($urandom_range(3));
        tick();
        chk("err_hold", 32'(state), E_ERROR);
        chk("err_led_on", 32'(error_led), 1);
        btn_valid = 1'b0;
        tick();
        chk("err_to_play", 32'(state), E_PLAY);
        chk("err_led_off", 32'(error_led), 0);
        chk("err_round", 32'(dut.round_cnt), 1);
        m_round = 1;
        m_idx   = 0;
    endtask

    task automatic play(input logic [1:0] val, input int hold, input bit poke);
        int res;
        press_check(val, hold, res);
        case (res)
            E_PLAY:  check_playback(poke);
            E_ERROR: begin
                recover();
                check_playback(poke);
            end
            E_INIT: begin
                check_init(4'hF);
                check_playback(poke);
            end
            default: ;
        endcase
    endtask

    initial begin
        int         res;
        logic [1:0] v;
        reset     = 1'b1;
        btn_valid = 1'b0;
        btn_val   = 2'd0;
        m_round   = 1;
        m_idx     = 0;
        tick();
        tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        check_init(4'h0);
        check_playback(1'b0);

        // Rounds 1-3 of the directed walk, ending with a wrong press and recovery.
        play(2'd0, 2, 1'b0);
        play(2'd0, 1, 1'b0);
        play(2'd1, 1, 1'b0);
        play(2'd3, 1, 1'b0);

        // Full win; one press held for five ticks must count once.
        play(2'd0, 1, 1'b0);
        play(2'd0, 5, 1'b0);
        play(2'd1, 1, 1'b0);
        for (int k = 0; k < 3; k++) play(2'(k), 1, 1'b0);
        for (int k = 0; k < 4; k++) play(2'(k), 1, 1'b1);

        for (int p = 0; p < 80; p++) begin
            v = 2'(m_idx % 4);
            if ($urandom_range(7) == 0) v = 2'((m_idx + 1 + int'($urandom_range(2))) % 4);
            play(v, 1 + int'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // Reset while in S_ERROR, then while in the middle of playback.
        press_check(2'((m_idx + 1) % 4), 1, res);
        chk("pre_reset_err", 32'(state), E_ERROR);
        reset = 1'b1;
        tick();
        chk_reset_vals("reset_err");
        reset = 1'b0;
        check_init(4'h0);
        tick();
        chk("mid_play", 32'(state), E_PLAY);
        reset = 1'b1;
        tick();
        chk_reset_vals("reset_play");
        reset = 1'b0;
        check_init(4'h0);
        check_playback(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
